// File: rtl/move_scheduler.sv
// Turn-order controller and single-write-port arbiter for the Connect-Four board.
// Optional per-turn forced pass is compiled in when MOVE_TIMEOUT_EN is defined.
module move_scheduler #(
  parameter int COLS           = 7,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TW             = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       req_a,
  input  logic [2:0] col_a,
  input  logic       req_b,
  input  logic [2:0] col_b,
  output logic       ack_a,
  output logic       ack_b,
  output logic       nack,
  output logic       brd_wr,
  output logic [2:0] brd_col,
  output logic       brd_player,
  input  logic       brd_done,
  input  logic       brd_invalid,
  input  logic       brd_win,
  input  logic       brd_full,
  output logic       turn,
  output logic       game_over,
  output logic [1:0] winner,
  output logic       timeout
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_REQ, S_WAIT_BRD, S_DONE} state_t;

  localparam logic [3:0] COLS_L = 4'(COLS);

  if (COLS < 1 || COLS > 8 || TIMEOUT_CYCLES < 2 || (2 ** TW) <= TIMEOUT_CYCLES) begin : g_bad_cfg
    $error("move_scheduler: illegal COLS/TIMEOUT_CYCLES/TW combination");
  end

  state_t     r_state, w_state_nxt;
  logic       r_turn, w_turn_nxt;
  logic [1:0] r_winner, w_winner_nxt;
  logic [2:0] r_col, w_col_nxt;
  logic       r_player, w_player_nxt;
  logic       r_ack_a, w_ack_a_nxt;
  logic       r_ack_b, w_ack_b_nxt;
  logic       r_nack, w_nack_nxt;
  logic       r_wr, w_wr_nxt;

  logic       w_req;
  logic [2:0] w_col;
  logic       w_col_ok;

  // Only the player holding the turn is ever looked at.
  assign w_req    = r_turn ? req_b : req_a;
  assign w_col    = r_turn ? col_b : col_a;
  assign w_col_ok = ({1'b0, w_col} < COLS_L);

`ifdef MOVE_TIMEOUT_EN
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] r_cnt, w_cnt_nxt;
  logic          r_timeout, w_timeout_nxt;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_turn_nxt   = r_turn;
    w_winner_nxt = r_winner;
    w_col_nxt    = r_col;
    w_player_nxt = r_player;
    w_ack_a_nxt  = 1'b0;
    w_ack_b_nxt  = 1'b0;
    w_nack_nxt   = 1'b0;
    w_wr_nxt     = 1'b0;
`ifdef MOVE_TIMEOUT_EN
    w_cnt_nxt     = r_cnt;
    w_timeout_nxt = 1'b0;
`endif
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt  = S_WAIT_REQ;
          w_turn_nxt   = 1'b0;
          w_winner_nxt = 2'b00;
`ifdef MOVE_TIMEOUT_EN
          w_cnt_nxt    = '0;
`endif
        end
      end
      S_WAIT_REQ: begin
        if (w_req && w_col_ok) begin
          w_ack_a_nxt  = ~r_turn;
          w_ack_b_nxt  = r_turn;
          w_wr_nxt     = 1'b1;
          w_col_nxt    = w_col;
          w_player_nxt = r_turn;
          w_state_nxt  = S_WAIT_BRD;
`ifdef MOVE_TIMEOUT_EN
          w_cnt_nxt    = '0;
`endif
        end else begin
          w_nack_nxt = w_req;
`ifdef MOVE_TIMEOUT_EN
          // A rejected column does not restart the stall window.
          if (r_cnt == TO_LAST) begin
            w_timeout_nxt = 1'b1;
            w_turn_nxt    = ~r_turn;
            w_cnt_nxt     = '0;
          end else begin
            w_cnt_nxt = r_cnt + TW'(1);
          end
`endif
        end
      end
      S_WAIT_BRD: begin
        if (brd_done) begin
          if (brd_invalid) begin
            w_nack_nxt  = 1'b1;
            w_state_nxt = S_WAIT_REQ;
          end else if (brd_win) begin
            w_winner_nxt = {r_turn, ~r_turn};
            w_state_nxt  = S_DONE;
          end else if (brd_full) begin
            w_winner_nxt = 2'b00;
            w_state_nxt  = S_DONE;
          end else begin
            w_turn_nxt  = ~r_turn;
            w_state_nxt = S_WAIT_REQ;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_turn    <= 1'b0;
      r_winner  <= 2'b00;
      r_col     <= 3'd0;
      r_player  <= 1'b0;
      r_ack_a   <= 1'b0;
      r_ack_b   <= 1'b0;
      r_nack    <= 1'b0;
      r_wr      <= 1'b0;
`ifdef MOVE_TIMEOUT_EN
      r_cnt     <= '0;
      r_timeout <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_turn    <= w_turn_nxt;
      r_winner  <= w_winner_nxt;
      r_col     <= w_col_nxt;
      r_player  <= w_player_nxt;
      r_ack_a   <= w_ack_a_nxt;
      r_ack_b   <= w_ack_b_nxt;
      r_nack    <= w_nack_nxt;
      r_wr      <= w_wr_nxt;
`ifdef MOVE_TIMEOUT_EN
      r_cnt     <= w_cnt_nxt;
      r_timeout <= w_timeout_nxt;
`endif
    end
  end

  assign ack_a      = r_ack_a;
  assign ack_b      = r_ack_b;
  assign nack       = r_nack;
  assign brd_wr     = r_wr;
  assign brd_col    = r_col;
  assign brd_player = r_player;
  assign turn       = r_turn;
  assign winner     = r_winner;
  assign game_over  = (r_state == S_DONE);
`ifdef MOVE_TIMEOUT_EN
  assign timeout    = r_timeout;
`else
  assign timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_move_scheduler.sv
// Bench for move_scheduler: directed game scenarios followed by random traffic,
// all outputs compared every cycle against a behavioural game model.
module tb_move_scheduler;
  localparam int COLS = 7;
  localparam int TOC  = 8;
  localparam int TW   = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       req_a = 1'b0, req_b = 1'b0;
  logic [2:0] col_a = 3'd0, col_b = 3'd0;
  logic       brd_done = 1'b0, brd_invalid = 1'b0, brd_win = 1'b0, brd_full = 1'b0;
  logic       ack_a, ack_b, nack, brd_wr, brd_player, turn, game_over, timeout;
  logic [2:0] brd_col;
  logic [1:0] winner;

  int n_vec = 0;
  int n_err = 0;

  move_scheduler #(.COLS(COLS), .TIMEOUT_CYCLES(TOC), .TW(TW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .req_a(req_a), .col_a(col_a), .req_b(req_b), .col_b(col_b),
    .ack_a(ack_a), .ack_b(ack_b), .nack(nack),
    .brd_wr(brd_wr), .brd_col(brd_col), .brd_player(brd_player),
    .brd_done(brd_done), .brd_invalid(brd_invalid), .brd_win(brd_win), .brd_full(brd_full),
    .turn(turn), .game_over(game_over), .winner(winner), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Game model: is a game running, is a move on the board, whose turn, idle time.
  bit         m_in_game, m_on_board, m_over, m_turn, m_player;
  bit         m_ack_a, m_ack_b, m_nack, m_wr, m_to;
  logic [1:0] m_winner;
  logic [2:0] m_col;
  int         m_idle;

  task automatic model_reset();
    m_in_game = 0; m_on_board = 0; m_over = 0; m_turn = 0; m_player = 0;
    m_ack_a = 0; m_ack_b = 0; m_nack = 0; m_wr = 0; m_to = 0;
    m_winner = 2'b00; m_col = 3'd0; m_idle = 0;
  endtask

  task automatic model_edge();
    bit       r;
    int       c;
    m_ack_a = 0; m_ack_b = 0; m_nack = 0; m_wr = 0; m_to = 0;
    if (!m_in_game) begin
      if (start) begin
        m_in_game = 1; m_on_board = 0; m_over = 0;
        m_turn = 0; m_winner = 2'b00; m_idle = 0;
      end
    end else if (!m_on_board) begin
      r = m_turn ? req_b : req_a;
      c = m_turn ? int'(col_b) : int'(col_a);
      if (r && c < COLS) begin
        if (m_turn) m_ack_b = 1; else m_ack_a = 1;
        m_wr = 1; m_col = 3'(c); m_player = m_turn; m_idle = 0; m_on_board = 1;
      end else begin
        m_nack = r;
`ifdef MOVE_TIMEOUT_EN
        if (m_idle == TOC - 1) begin
          m_to = 1; m_turn = ~m_turn; m_idle = 0;
        end else begin
          m_idle++;
        end
`endif
      end
    end else if (brd_done) begin
      if (brd_invalid) begin
        m_nack = 1; m_on_board = 0;
      end else if (brd_win) begin
        m_winner = m_turn ? 2'b10 : 2'b01; m_over = 1; m_in_game = 0;
      end else if (brd_full) begin
        m_winner = 2'b00; m_over = 1; m_in_game = 0;
      end else begin
        m_turn = ~m_turn; m_on_board = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("ack_a", 8'(ack_a), 8'(m_ack_a));
    chk("ack_b", 8'(ack_b), 8'(m_ack_b));
    chk("nack", 8'(nack), 8'(m_nack));
    chk("brd_wr", 8'(brd_wr), 8'(m_wr));
    chk("brd_col", 8'(brd_col), 8'(m_col));
    chk("brd_player", 8'(brd_player), 8'(m_player));
    chk("turn", 8'(turn), 8'(m_turn));
    chk("game_over", 8'(game_over), 8'(m_over));
    chk("winner", 8'(winner), 8'(m_winner));
    chk("timeout", 8'(timeout), 8'(m_to));
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!rst) model_reset(); else model_edge();
    #1;
    check_all();
  endtask

  initial begin
    #1 rst = 1'b0;
    #1 model_reset();
    check_all();
    cyc(); cyc();
    rst = 1'b1;
    cyc(); cyc();

    // Basic alternation
    start = 1; cyc(); start = 0;
    req_a = 1; col_a = 3'd3; cyc();
    chk("alt_ack_a", 8'(ack_a), 8'd1);
    chk("alt_wr", 8'(brd_wr), 8'd1);
    chk("alt_col", 8'(brd_col), 8'd3);
    chk("alt_player_a", 8'(brd_player), 8'd0);
    req_a = 0; brd_done = 1; cyc(); brd_done = 0;
    chk("alt_turn_b", 8'(turn), 8'd1);
    req_b = 1; col_b = 3'd4; cyc();
    chk("alt_player_b", 8'(brd_player), 8'd1);
    req_b = 0; brd_done = 1; cyc(); brd_done = 0;
    chk("alt_turn_a", 8'(turn), 8'd0);

    // Wrong turn, then bad column
    req_b = 1; col_b = 3'd2; repeat (3) cyc();
    chk("wrong_turn_ack", 8'(ack_b), 8'd0);
    chk("wrong_turn_nack", 8'(nack), 8'd0);
    req_b = 0; req_a = 1; col_a = 3'd7; cyc();
    chk("badcol_nack", 8'(nack), 8'd1);
    chk("badcol_turn", 8'(turn), 8'd0);
    req_a = 0; cyc();
    chk("badcol_nack_pulse", 8'(nack), 8'd0);

    // Board rejects the move, retry accepted
    req_a = 1; col_a = 3'd0; cyc();
    req_a = 0; brd_done = 1; brd_invalid = 1; cyc(); brd_done = 0; brd_invalid = 0;
    chk("inv_nack", 8'(nack), 8'd1);
    chk("inv_turn", 8'(turn), 8'd0);
    req_a = 1; col_a = 3'd1; cyc();
    chk("retry_ack", 8'(ack_a), 8'd1);
    chk("retry_col", 8'(brd_col), 8'd1);
    req_a = 0; brd_done = 1; cyc(); brd_done = 0;

    // B wins with board also full
    req_b = 1; col_b = 3'd5; cyc();
    req_b = 0; brd_done = 1; brd_win = 1; brd_full = 1; cyc();
    brd_done = 0; brd_win = 0; brd_full = 0;
    chk("win_over", 8'(game_over), 8'd1);
    chk("win_winner", 8'(winner), 8'd2);
    req_a = 1; col_a = 3'd2; req_b = 1; col_b = 3'd2; repeat (3) cyc();
    chk("done_no_wr", 8'(brd_wr), 8'd0);
    chk("done_hold", 8'(game_over), 8'd1);
    req_a = 0; req_b = 0;
    start = 1; cyc(); start = 0;
    chk("restart_turn", 8'(turn), 8'd0);
    chk("restart_winner", 8'(winner), 8'd0);
    chk("restart_over", 8'(game_over), 8'd0);

    // Stalled player
    repeat (TOC) cyc();
`ifdef MOVE_TIMEOUT_EN
    chk("to_pulse", 8'(timeout), 8'd1);
    chk("to_turn", 8'(turn), 8'd1);
    cyc();
    chk("to_pulse_end", 8'(timeout), 8'd0);
`else
    repeat (100 - TOC) cyc();
    chk("no_to_turn", 8'(turn), 8'd0);
    chk("no_to_pulse", 8'(timeout), 8'd0);
`endif

    // Async reset while the board is busy
    req_a = 1; col_a = 3'd2; req_b = 1; col_b = 3'd2; cyc();
    req_a = 0; req_b = 0;
    chk("pre_rst_wr", 8'(brd_wr), 8'd1);
    #2 rst = 1'b0;
    #1 model_reset();
    check_all();
    chk("rst_col", 8'(brd_col), 8'd0);
    cyc();
    rst = 1'b1; brd_done = 1; repeat (3) cyc(); brd_done = 0;
    chk("post_rst_turn", 8'(turn), 8'd0);
    chk("post_rst_over", 8'(game_over), 8'd0);

    // Random traffic
    start = 1; cyc(); start = 0;
    for (int i = 0; i < 600; i++) begin
      start       = ($urandom_range(0, 15) == 0);
      req_a       = 1'($urandom_range(0, 1));
      req_b       = 1'($urandom_range(0, 1));
      col_a       = 3'($urandom_range(0, 7));
      col_b       = 3'($urandom_range(0, 7));
      brd_done    = 1'($urandom_range(0, 1));
      brd_invalid = ($urandom_range(0, 5) == 0);
      brd_win     = ($urandom_range(0, 9) == 0);
      brd_full    = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 149) == 0) begin
        #2 rst = 1'b0;
        #1 model_reset();
        check_all();
        #1 rst = 1'b1;
      end
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
